// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage with register file, immediate generator, control decoder and branch-target adder
package decode_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       is_branch;
    logic       is_jump;
    logic [1:0] alu_op;
  } control_type;
endpackage

module decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  input  logic        RegWrite,
  input  logic [31:0] write_data,
  input  logic [4:0]  write_id,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output control_type control,
  output logic [31:0] pc_branch
);
  logic [31:0] regs [32];
  logic [6:0]  opcode;
  logic        wr_hit;
  assign opcode = instruction[6:0];
  assign rd = instruction[11:7];
  assign rs1 = instruction[19:15];
  assign rs2 = instruction[24:20];
  assign wr_hit = RegWrite && write_id != 5'd0;
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (wr_hit)
      regs[write_id] <= write_data;
  assign data1 = !rst ? '0 : (wr_hit && write_id == rs1) ? write_data : rs1 == 5'd0 ? '0 : regs[rs1];
  assign data2 = !rst ? '0 : (wr_hit && write_id == rs2) ? write_data : rs2 == 5'd0 ? '0 : regs[rs2];
  always_comb begin
    imm = '0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: imm = {{20{instruction[31]}}, instruction[31:20]};
      7'b0100011: imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      7'b1100011: imm = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm = {instruction[31:12], 12'b0};
      7'b1101111: imm = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
  assign pc_branch = pc + imm;
  always_comb begin
    control = '0;
    case (opcode)
      7'b0110011: begin
        control.reg_write = 1'b1;
        control.alu_op = 2'b10;
      end
      7'b0010011: begin
        control.reg_write = 1'b1;
        control.alu_src = 1'b1;
        control.alu_op = 2'b11;
      end
      7'b0000011: begin
        control.reg_write = 1'b1;
        control.mem_read = 1'b1;
        control.mem_to_reg = 1'b1;
        control.alu_src = 1'b1;
      end
      7'b0100011: begin
        control.mem_write = 1'b1;
        control.alu_src = 1'b1;
      end
      7'b1100011: begin
        control.is_branch = 1'b1;
        control.alu_op = 2'b01;
      end
      7'b0110111, 7'b0010111: begin
        control.reg_write = 1'b1;
        control.alu_src = 1'b1;
      end
      7'b1101111: begin
        control.reg_write = 1'b1;
        control.is_jump = 1'b1;
      end
      7'b1100111: begin
        control.reg_write = 1'b1;
        control.is_jump = 1'b1;
        control.alu_src = 1'b1;
      end
      default: control = '0;
    endcase
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage
module tb_decode_stage;
  import decode_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] pc = '0;
  logic        RegWrite = 1'b0;
  logic [31:0] write_data = '0;
  logic [4:0]  write_id = '0;
  logic [31:0] data1, data2, imm, pc_branch;
  logic [4:0]  rd, rs1, rs2;
  control_type control;
  int n_checks = 0;
  int n_fail = 0;
  localparam logic [31:0] ADDI = {12'd3, 5'd2, 3'b000, 5'd3, 7'b0010011};
  decode_stage dut (
    .clk(clk), .rst(rst), .instruction(instruction), .pc(pc),
    .RegWrite(RegWrite), .write_data(write_data), .write_id(write_id),
    .data1(data1), .data2(data2), .imm(imm), .rd(rd), .rs1(rs1), .rs2(rs2),
    .control(control), .pc_branch(pc_branch)
  );
  always #5 clk = ~clk;
  task automatic test_reset;
    rst = 1'b0;
    instruction = ADDI;
    pc = '0;
    #1;
    n_checks++; if (data1 !== 32'd0) begin n_fail++; $display("FAIL reset_data1_in_reset: got %h want %h", data1, 32'd0); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (imm !== 32'd3) begin n_fail++; $display("FAIL reset_imm: got %h want %h", imm, 32'd3); end
    n_checks++; if (rd !== 5'd3 || rs1 !== 5'd2 || rs2 !== 5'd3) begin n_fail++; $display("FAIL reset_fields: got rd=%0d rs1=%0d rs2=%0d want 3 2 3", rd, rs1, rs2); end
    n_checks++; if (data1 !== 32'd0) begin n_fail++; $display("FAIL reset_data1: got %h want %h", data1, 32'd0); end
    n_checks++; if (control !== 9'b1_0_0_0_1_0_0_11) begin n_fail++; $display("FAIL reset_control: got %b want %b", control, 9'b1_0_0_0_1_0_0_11); end
    n_checks++; if (pc_branch !== 32'd3) begin n_fail++; $display("FAIL reset_pc_branch: got %h want %h", pc_branch, 32'd3); end
  endtask
  task automatic test_writeback;
    @(negedge clk);
    RegWrite = 1'b1;
    write_id = 5'd2;
    write_data = 32'd5;
    @(negedge clk);
    RegWrite = 1'b0;
    write_data = '0;
    #1;
    n_checks++; if (data1 !== 32'd5) begin n_fail++; $display("FAIL wb_data1: got %h want %h", data1, 32'd5); end
    rst = 1'b0;
    #1;
    n_checks++; if (data1 !== 32'd0) begin n_fail++; $display("FAIL wb_rst_data1: got %h want %h", data1, 32'd0); end
    n_checks++; if (imm !== 32'd3 || control !== 9'b1_0_0_0_1_0_0_11) begin n_fail++; $display("FAIL wb_rst_decode: got imm=%h ctl=%b want 3 110001011", imm, control); end
    rst = 1'b1;
    #1;
    n_checks++; if (data1 !== 32'd0) begin n_fail++; $display("FAIL wb_cleared: got %h want %h", data1, 32'd0); end
  endtask
  task automatic test_x0;
    @(negedge clk);
    instruction = {12'd0, 5'd0, 3'b000, 5'd1, 7'b0010011};
    RegWrite = 1'b1;
    write_id = 5'd0;
    write_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (data1 !== 32'd0) begin n_fail++; $display("FAIL x0_bypass: got %h want %h", data1, 32'd0); end
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    n_checks++; if (data1 !== 32'd0) begin n_fail++; $display("FAIL x0_read: got %h want %h", data1, 32'd0); end
  endtask
  task automatic test_bypass;
    @(negedge clk);
    instruction = {7'd0, 5'd2, 5'd2, 3'b000, 5'd1, 7'b0110011};
    RegWrite = 1'b1;
    write_id = 5'd2;
    write_data = 32'd7;
    #1;
    n_checks++; if (data1 !== 32'd7 || data2 !== 32'd7) begin n_fail++; $display("FAIL bypass_pre: got %h %h want 7 7", data1, data2); end
    n_checks++; if (control !== 9'b1_0_0_0_0_0_0_10) begin n_fail++; $display("FAIL rtype_control: got %b want %b", control, 9'b1_0_0_0_0_0_0_10); end
    @(negedge clk);
    RegWrite = 1'b0;
    write_data = '0;
    #1;
    n_checks++; if (data1 !== 32'd7 || data2 !== 32'd7) begin n_fail++; $display("FAIL bypass_stored: got %h %h want 7 7", data1, data2); end
    write_id = 5'd3;
    write_data = 32'd9;
    #1;
    n_checks++; if (data1 !== 32'd7) begin n_fail++; $display("FAIL bypass_disabled: got %h want %h", data1, 32'd7); end
  endtask
  task automatic test_branch;
    @(negedge clk);
    instruction = 32'hFE000CE3;
    pc = 32'h100;
    #1;
    n_checks++; if (imm !== 32'hFFFFFFF8) begin n_fail++; $display("FAIL beq_imm: got %h want %h", imm, 32'hFFFFFFF8); end
    n_checks++; if (pc_branch !== 32'h000000F8) begin n_fail++; $display("FAIL beq_pc_branch: got %h want %h", pc_branch, 32'h000000F8); end
    n_checks++; if (control !== 9'b0_0_0_0_0_1_0_01) begin n_fail++; $display("FAIL beq_control: got %b want %b", control, 9'b0_0_0_0_0_1_0_01); end
  endtask
  task automatic test_immediates;
    @(negedge clk);
    pc = '0;
    instruction = {7'h7F, 5'd5, 5'd2, 3'b010, 5'b11100, 7'b0100011};
    #1;
    n_checks++; if (imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL sw_imm: got %h want %h", imm, 32'hFFFFFFFC); end
    n_checks++; if (control !== 9'b0_0_1_0_1_0_0_00) begin n_fail++; $display("FAIL sw_control: got %b want %b", control, 9'b0_0_1_0_1_0_0_00); end
    instruction = {12'd16, 5'd2, 3'b010, 5'd4, 7'b0000011};
    #1;
    n_checks++; if (imm !== 32'd16) begin n_fail++; $display("FAIL lw_imm: got %h want %h", imm, 32'd16); end
    n_checks++; if (control !== 9'b1_1_0_1_1_0_0_00) begin n_fail++; $display("FAIL lw_control: got %b want %b", control, 9'b1_1_0_1_1_0_0_00); end
    instruction = {1'b0, 10'd0, 1'b1, 8'd0, 5'd1, 7'b1101111};
    #1;
    n_checks++; if (imm !== 32'h800 || pc_branch !== 32'h800) begin n_fail++; $display("FAIL jal_imm: got imm=%h pc_branch=%h want 800 800", imm, pc_branch); end
    n_checks++; if (control !== 9'b1_0_0_0_0_0_1_00) begin n_fail++; $display("FAIL jal_control: got %b want %b", control, 9'b1_0_0_0_0_0_1_00); end
    instruction = {12'd4, 5'd1, 3'b000, 5'd1, 7'b1100111};
    #1;
    n_checks++; if (imm !== 32'd4 || control !== 9'b1_0_0_0_1_0_1_00) begin n_fail++; $display("FAIL jalr: got imm=%h ctl=%b want 4 100010100", imm, control); end
    instruction = {20'h12345, 5'd5, 7'b0110111};
    #1;
    n_checks++; if (imm !== 32'h12345000 || control !== 9'b1_0_0_0_1_0_0_00) begin n_fail++; $display("FAIL lui: got imm=%h ctl=%b want 12345000 100010000", imm, control); end
    instruction = 32'hFFFFFF80;
    #1;
    n_checks++; if (imm !== 32'd0 || control !== 9'd0) begin n_fail++; $display("FAIL unknown_op: got imm=%h ctl=%b want 0 0", imm, control); end
  endtask
  initial begin
    test_reset();
    test_writeback();
    test_x0();
    test_bypass();
    test_branch();
    test_immediates();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
